// File: rtl/multiplier_pipe.sv
// Signed 32x32 -> 64-bit multiplier with five register stages.
// Stage 1 registers the operands. Radix-4 Booth generates 16 partial products.
// A carry-save tree reduces them over stages 2-4: 16 -> 8 -> 4 -> 2.
// A carry-propagate add feeds the stage-5 output register.
module multiplier_pipe (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [63:0] P
);

    typedef logic [63:0] word_t;

    typedef struct packed {
        word_t c;
        word_t s;
    } csa_t;

    // 3:2 compressor over full 64-bit words.
    // The carry is shifted into weight and truncated, so the sum stays exact modulo 2^64.
    function automatic csa_t csa(input word_t x, input word_t y, input word_t z);
        csa_t r;
        r.s = x ^ y ^ z;
        r.c = ((x & y) | (x & z) | (y & z)) << 1;
        return r;
    endfunction

    // ---------------- stage 1: operand registers ----------------
    logic [31:0] a_d, a_q;
    logic [31:0] b_d, b_q;

    // Operands are taken unconditionally on every edge; there is no handshake.
    always_comb begin
        a_d = A;
        b_d = B;
    end

    // Stage-1 operand flops.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    // ---------------- Booth partial products ----------------
    logic [15:0][63:0] pp;

    // Radix-4 Booth recoding of b_q. An implicit 0 is appended below bit 0.
    // Digit i scans b[2i+1:2i-1] and selects 0, +-A or +-2A, shifted by 2i.
    // b[31] acts as the sign bit, so the top digit absorbs its negative weight.
    always_comb begin
        word_t       a_ext;
        word_t       m;
        logic [32:0] b_ext;
        logic [2:0]  trip;
        a_ext = {{32{a_q[31]}}, a_q};
        b_ext = {b_q, 1'b0};
        m     = '0;
        trip  = '0;
        pp    = '0;
        for (int i = 0; i < 16; i++) begin
            trip = b_ext[2*i+2 -: 3];
            unique case (trip)
                3'b001, 3'b010: m = a_ext;
                3'b011:         m = a_ext << 1;
                3'b100:         m = ~(a_ext << 1) + 64'd1;
                3'b101, 3'b110: m = ~a_ext + 64'd1;
                default:        m = '0;
            endcase
            pp[i] = m << (2 * i);
        end
    end

    // ---------------- stage 2: 16 -> 8 ----------------
    logic [7:0][63:0] s2_d, s2_q;

    // First two CSA layers: 16 -> 11 -> 8.
    always_comb begin
        logic [10:0][63:0] l1;
        csa_t              r;
        l1   = '0;
        s2_d = '0;
        for (int j = 0; j < 5; j++) begin
            r           = csa(pp[3*j], pp[3*j+1], pp[3*j+2]);
            l1[2*j]     = r.s;
            l1[2*j+1]   = r.c;
        end
        l1[10] = pp[15];
        for (int j = 0; j < 3; j++) begin
            r           = csa(l1[3*j], l1[3*j+1], l1[3*j+2]);
            s2_d[2*j]   = r.s;
            s2_d[2*j+1] = r.c;
        end
        s2_d[6] = l1[9];
        s2_d[7] = l1[10];
    end

    // Stage-2 partial-sum flops.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) s2_q <= '0;
        else       s2_q <= s2_d;
    end

    // ---------------- stage 3: 8 -> 4 ----------------
    logic [3:0][63:0] s3_d, s3_q;

    // Two CSA layers: 8 -> 6 -> 4.
    always_comb begin
        logic [5:0][63:0] l3;
        csa_t             r;
        l3    = '0;
        s3_d  = '0;
        r     = csa(s2_q[0], s2_q[1], s2_q[2]);
        l3[0] = r.s;
        l3[1] = r.c;
        r     = csa(s2_q[3], s2_q[4], s2_q[5]);
        l3[2] = r.s;
        l3[3] = r.c;
        l3[4] = s2_q[6];
        l3[5] = s2_q[7];
        r       = csa(l3[0], l3[1], l3[2]);
        s3_d[0] = r.s;
        s3_d[1] = r.c;
        r       = csa(l3[3], l3[4], l3[5]);
        s3_d[2] = r.s;
        s3_d[3] = r.c;
    end

    // Stage-3 partial-sum flops.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) s3_q <= '0;
        else       s3_q <= s3_d;
    end

    // ---------------- stage 4: 4 -> 2 ----------------
    word_t sum_d, sum_q;
    word_t cry_d, cry_q;

    // Two CSA layers: 4 -> 3 -> 2, leaving redundant sum/carry form.
    always_comb begin
        csa_t r;
        r     = csa(s3_q[0], s3_q[1], s3_q[2]);
        r     = csa(r.s, r.c, s3_q[3]);
        sum_d = r.s;
        cry_d = r.c;
    end

    // Stage-4 sum/carry flops.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            sum_q <= '0;
            cry_q <= '0;
        end else begin
            sum_q <= sum_d;
            cry_q <= cry_d;
        end
    end

    // ---------------- stage 5: carry-propagate add ----------------
    word_t p_d, p_q;

    // Final carry-propagate add into the output register.
    always_comb begin
        p_d = sum_q + cry_q;
    end

    // Output register. P comes straight from this flop, with no bypass path.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) p_q <= '0;
        else       p_q <= p_d;
    end

    assign P = p_q;

endmodule

// File: tb/tb_multiplier_pipe.sv
// Scoreboard bench for multiplier_pipe.
// The driver pushes one expected product per sampling edge.
// The monitor pops and compares each product four edges after it was sampled.
module tb_multiplier_pipe;

    logic        CLK;
    logic        RSTN;
    logic [31:0] A;
    logic [31:0] B;
    logic [63:0] P;

    typedef struct {
        string       nm;
        logic [63:0] exp;
    } item_t;

    item_t exp_q[$];
    int    total = 0;
    int    bad   = 0;
    int    edge_cnt = 0;

    multiplier_pipe dut (
        .CLK  (CLK),
        .RSTN (RSTN),
        .A    (A),
        .B    (B),
        .P    (P)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Drive one operand pair away from the sampling edge and record its expected product.
    task automatic drive(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp);
        item_t it;
        @(negedge CLK);
        A = a;
        B = b;
        it.nm  = nm;
        it.exp = exp;
        exp_q.push_back(it);
    endtask

    // Release reset at a falling edge, so the next rising edge is the first sampling edge.
    task automatic release_rst();
        item_t it;
        @(negedge CLK);
        RSTN = 1'b1;
        A = '0;
        B = '0;
        it.nm  = "zero_after_rst";
        it.exp = '0;
        exp_q.push_back(it);
    endtask

    // Products still in flight are discarded by reset, so drop their expectations too.
    always @(negedge RSTN) begin
        exp_q.delete();
        edge_cnt = 0;
    end

    // Monitor: before the 5th sampling edge P must still read 0.
    // From then on it must equal the product sampled 4 edges earlier.
    initial begin
        item_t it;
        forever begin
            @(posedge CLK);
            if (RSTN) begin
                edge_cnt++;
                #1;
                if (edge_cnt >= 5) begin
                    if (exp_q.size() == 0) begin
                        chk("queue_underflow", P, 64'hDEAD);
                    end else begin
                        it = exp_q.pop_front();
                        chk(it.nm, P, it.exp);
                    end
                end else begin
                    chk("fill_zero", P, 64'd0);
                end
            end
        end
    end

    initial begin
        logic [31:0] ra, rb;
        longint      rp;
        RSTN = 1'b0;
        A = '0;
        B = '0;
        #3;
        chk("reset_state", P, 64'd0);
        repeat (2) @(negedge CLK);
        release_rst();
        repeat (3) drive("idle", 32'd0, 32'd0, 64'd0);

        // Directed vectors with hand-computed products.
        drive("3x5",        32'd3,          32'd5,          64'h000000000000000F);
        drive("m1xm1",      32'hFFFFFFFF,   32'hFFFFFFFF,   64'h0000000000000001);
        drive("m1x2",       32'hFFFFFFFF,   32'h00000002,   64'hFFFFFFFFFFFFFFFE);
        drive("maxpos_sq",  32'h7FFFFFFF,   32'h7FFFFFFF,   64'h3FFFFFFF00000001);
        drive("minneg_sq",  32'h80000000,   32'h80000000,   64'h4000000000000000);
        drive("minneg_xm1", 32'h80000000,   32'hFFFFFFFF,   64'h0000000080000000);
        drive("x_zero",     32'h12345678,   32'h00000000,   64'h0000000000000000);
        drive("zero_x",     32'h00000000,   32'h80000000,   64'h0000000000000000);
        drive("maxpos_xmin",32'h7FFFFFFF,   32'h80000000,   64'hC000000080000000);
        drive("s_1x1",      32'd1,          32'd1,          64'd1);
        drive("s_2x3",      32'd2,          32'd3,          64'd6);
        drive("s_m4x5",     32'hFFFFFFFC,   32'd5,          64'hFFFFFFFFFFFFFFEC);
        drive("s_1e5sq",    32'd100000,     32'd100000,     64'h00000002540BE400);
        repeat (5) drive("drain", 32'd0, 32'd0, 64'd0);

        // Mid-pipeline reset: the 7*9 product is in flight and must never emerge.
        drive("inflight", 32'd7, 32'd9, 64'd0);
        drive("inflight_next", 32'd0, 32'd0, 64'd0);
        @(posedge CLK);
        #2;
        RSTN = 1'b0;
        #1;
        chk("rst_async", P, 64'd0);
        @(negedge CLK);
        chk("rst_hold", P, 64'd0);
        @(negedge CLK);
        release_rst();
        repeat (8) drive("no_63", 32'd0, 32'd0, 64'd0);
        drive("7x9_again", 32'd7, 32'd9, 64'd63);

        // Random regression against a plain signed product.
        for (int i = 0; i < 10000; i++) begin
            ra = $urandom;
            rb = $urandom;
            rp = longint'($signed(ra)) * longint'($signed(rb));
            drive("random", ra, rb, 64'(rp));
        end
        repeat (6) drive("tail", 32'd0, 32'd0, 64'd0);
        @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard cycle bound so the run always ends.
    initial begin
        #500000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
